// File: rtl/vitality_pkg.sv
// Shared types for the vitality state controller and consumers of state_out:
// state encoding, rate-enable bundle order and the per-state enable decode.
package vitality_pkg;

  typedef enum logic [1:0] {
    ST_AWAKE  = 2'b00,
    ST_ASLEEP = 2'b01,
    ST_DYING  = 2'b10,
    ST_DEAD   = 2'b11
  } vit_state_e;

  // Bundle order, MSB first: en_inc, en_dec, st_dec, pl_inc.
  typedef struct packed {
    logic en_inc;
    logic en_dec;
    logic st_dec;
    logic pl_inc;
  } rate_en_t;

  localparam int RATE_EN_W = $bits(rate_en_t);

  function automatic int cnt_width(input int max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

  function automatic rate_en_t decode_rate_en(input vit_state_e st);
    rate_en_t r;
    r = '0;
    case (st)
      ST_AWAKE:  r.en_dec = 1'b1;
      ST_ASLEEP: begin
        r.en_inc = 1'b1;
        r.st_dec = 1'b1;
        r.pl_inc = 1'b1;
      end
      ST_DYING:  r.en_dec = 1'b1;
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vitality_state_controller_sat_tick_counter.sv
// Saturating up-counter: synchronous clear, tick-gated increment, stops at LIMIT
// and flags when it sits there. Used for the sleep and dying counters.
module sat_tick_counter
  import vitality_pkg::*;
#(
  parameter int LIMIT = 4,
  parameter int CNT_W = cnt_width(LIMIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  input  logic inc,
  output logic at_limit
);

  localparam logic [CNT_W-1:0] LIMIT_Q = CNT_W'(LIMIT);

  if (LIMIT < 0) begin : g_bad_limit
    $error("sat_tick_counter: LIMIT must be non-negative");
  end

  logic [CNT_W-1:0] cnt;

  // Clear wins over increment; the count never wraps past LIMIT.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick && inc && !at_limit) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt >= LIMIT_Q);

endmodule

// File: rtl/vitality_state_controller.sv
// Physical-state FSM (AWAKE/ASLEEP/DYING/DEAD) with tick-gated updates, sleep/wake
// hysteresis, minimum sleep and internal death timeout. Optional: VITALITY_REVIVE_EN.
module vitality_state_controller
  import vitality_pkg::*;
#(
  parameter int IND_W           = 2,
  parameter int SLEEP_LVL       = 1,
  parameter int WAKE_LVL        = 3,
  parameter int STRESS_WAKE_LVL = 2,
  parameter int MIN_SLEEP_TICKS = 4,
  parameter int DYING_TICKS     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [IND_W-1:0] energy_level,
  input  logic [IND_W-1:0] stress_level,
  input  logic             revive,
  output logic [1:0]       state_out,
  output logic             fell_asleep,
  output logic             woke_up,
  output logic             died,
  output logic             en_inc,
  output logic             en_dec,
  output logic             st_dec,
  output logic             pl_inc
);

  if (IND_W < 1) begin : g_bad_ind_w
    $error("vitality_state_controller: IND_W must be at least 1");
  end
  if (WAKE_LVL <= SLEEP_LVL) begin : g_bad_hyst
    $error("vitality_state_controller: WAKE_LVL must exceed SLEEP_LVL");
  end
  if (DYING_TICKS < 1) begin : g_bad_dying
    $error("vitality_state_controller: DYING_TICKS must be at least 1");
  end
  if (MIN_SLEEP_TICKS < 0) begin : g_bad_sleep
    $error("vitality_state_controller: MIN_SLEEP_TICKS must be non-negative");
  end

  localparam logic [IND_W-1:0] SLEEP_Q  = IND_W'(SLEEP_LVL);
  localparam logic [IND_W-1:0] WAKE_Q   = IND_W'(WAKE_LVL);
  localparam logic [IND_W-1:0] STRESS_Q = IND_W'(STRESS_WAKE_LVL);

  vit_state_e state_p0;
  vit_state_e state_nxt;
  logic       fell_nxt;
  logic       woke_nxt;
  logic       died_nxt;
  logic       sleep_clr;
  logic       sleep_inc;
  logic       sleep_done;
  logic       dying_clr;
  logic       dying_inc;
  logic       dying_done;
  logic       revive_req;
  logic       energy_zero;
  logic       stress_high;
  rate_en_t   rate_en;

  assign energy_zero = (energy_level == '0);
  assign stress_high = (stress_level >= STRESS_Q);

`ifdef VITALITY_REVIVE_EN
  assign revive_req = revive && (state_p0 == ST_DEAD);
`else
  logic revive_unused;
  assign revive_unused = revive;
  assign revive_req    = 1'b0;
`endif

  sat_tick_counter #(
    .LIMIT (MIN_SLEEP_TICKS)
  ) u_sleep_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (sleep_clr),
    .tick     (tick),
    .inc      (sleep_inc),
    .at_limit (sleep_done)
  );

  // Dying limit is DYING_TICKS-1: the tick that finds the counter there is the last one.
  sat_tick_counter #(
    .LIMIT (DYING_TICKS - 1)
  ) u_dying_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (dying_clr),
    .tick     (tick),
    .inc      (dying_inc),
    .at_limit (dying_done)
  );

  // State register and event pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0    <= ST_AWAKE;
      fell_asleep <= 1'b0;
      woke_up     <= 1'b0;
      died        <= 1'b0;
    end else begin
      state_p0    <= state_nxt;
      fell_asleep <= fell_nxt;
      woke_up     <= woke_nxt;
      died        <= died_nxt;
    end
  end

  // Next-state and counter control
  always_comb begin
    state_nxt = state_p0;
    fell_nxt  = 1'b0;
    woke_nxt  = 1'b0;
    died_nxt  = 1'b0;
    sleep_clr = 1'b0;
    sleep_inc = 1'b0;
    dying_clr = 1'b0;
    dying_inc = 1'b0;
    if (revive_req) begin
      state_nxt = ST_AWAKE;
      woke_nxt  = 1'b1;
      sleep_clr = 1'b1;
      dying_clr = 1'b1;
    end else begin
      case (state_p0)
        ST_AWAKE: begin
          if (tick && energy_zero) begin
            state_nxt = ST_DYING;
            dying_clr = 1'b1;
          end else if (tick && (energy_level <= SLEEP_Q) && !stress_high) begin
            state_nxt = ST_ASLEEP;
            fell_nxt  = 1'b1;
            sleep_clr = 1'b1;
          end
        end
        ST_ASLEEP: begin
          sleep_inc = 1'b1;
          if (tick && energy_zero) begin
            state_nxt = ST_DYING;
            dying_clr = 1'b1;
          end else if (tick && stress_high) begin
            state_nxt = ST_AWAKE;
            woke_nxt  = 1'b1;
          end else if (tick && (energy_level >= WAKE_Q) && sleep_done) begin
            state_nxt = ST_AWAKE;
            woke_nxt  = 1'b1;
          end
        end
        ST_DYING: begin
          if (tick && !energy_zero) begin
            state_nxt = ST_AWAKE;
            dying_clr = 1'b1;
          end else if (tick && dying_done) begin
            state_nxt = ST_DEAD;
            died_nxt  = 1'b1;
          end else begin
            dying_inc = energy_zero;
          end
        end
        ST_DEAD: state_nxt = ST_DEAD;
        default: state_nxt = ST_AWAKE;
      endcase
    end
  end

  // Rate enables decoded from the registered state
  always_comb begin
    rate_en = decode_rate_en(state_p0);
    en_inc  = rate_en.en_inc;
    en_dec  = rate_en.en_dec;
    st_dec  = rate_en.st_dec;
    pl_inc  = rate_en.pl_inc;
  end

  assign state_out = state_p0;

endmodule

// File: tb/tb_vitality_state_controller.sv
// Directed bench for vitality_state_controller at default parameters; the revive
// expectation follows whether VITALITY_REVIVE_EN is defined for the build.
module tb_vitality_state_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       revive = 1'b0;
  logic [1:0] energy_level = 2'd3;
  logic [1:0] stress_level = 2'd0;
  logic [1:0] state_out;
  logic       fell_asleep, woke_up, died;
  logic       en_inc, en_dec, st_dec, pl_inc;

  int checks = 0;
  int errors = 0;

  // {state_out, fell_asleep, woke_up, died, en_inc, en_dec, st_dec, pl_inc}
  localparam logic [8:0] AWK  = 9'b00_000_0100;
  localparam logic [8:0] ASL  = 9'b01_000_1011;
  localparam logic [8:0] DYG  = 9'b10_000_0100;
  localparam logic [8:0] DED  = 9'b11_000_0000;
  localparam logic [8:0] FELL = 9'b00_100_0000;
  localparam logic [8:0] WOKE = 9'b00_010_0000;
  localparam logic [8:0] DIED = 9'b00_001_0000;

  logic [8:0] obs;
  assign obs = {state_out, fell_asleep, woke_up, died, en_inc, en_dec, st_dec, pl_inc};

  vitality_state_controller dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .energy_level (energy_level),
    .stress_level (stress_level),
    .revive       (revive),
    .state_out    (state_out),
    .fell_asleep  (fell_asleep),
    .woke_up      (woke_up),
    .died         (died),
    .en_inc       (en_inc),
    .en_dec       (en_dec),
    .st_dec       (st_dec),
    .pl_inc       (pl_inc)
  );

  always #5 clk = ~clk;

  task automatic step(input logic t);
    tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    energy_level = 2'd3;
    stress_level = 2'd0;
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    energy_level = 2'd0;
    step(1'b1);
    checks++; if (obs !== AWK) begin errors++; $display("FAIL reset_state: got %b expected %b", obs, AWK); end
    step(1'b1);
    checks++; if (obs !== AWK) begin errors++; $display("FAIL reset_over_tick: got %b expected %b", obs, AWK); end
    rst = 1'b0;
    energy_level = 2'd3;
    step(1'b0);
    checks++; if (obs !== AWK) begin errors++; $display("FAIL reset_release: got %b expected %b", obs, AWK); end
  endtask

  task automatic test_fall_asleep();
    do_reset();
    energy_level = 2'd1;
    stress_level = 2'd0;
    step(1'b1);
    checks++; if (obs !== (ASL | FELL)) begin errors++; $display("FAIL fall_asleep: got %b expected %b", obs, ASL | FELL); end
    step(1'b0);
    checks++; if (obs !== ASL) begin errors++; $display("FAIL fall_pulse_end: got %b expected %b", obs, ASL); end
  endtask

  task automatic test_min_sleep();
    energy_level = 2'd1;
    step(1'b1);
    checks++; if (obs !== ASL) begin errors++; $display("FAIL min_sleep_t1: got %b expected %b", obs, ASL); end
    energy_level = 2'd3;
    for (int i = 2; i <= 4; i++) begin
      step(1'b1);
      checks++; if (obs !== ASL) begin errors++; $display("FAIL min_sleep_t%0d: got %b expected %b", i, obs, ASL); end
    end
    step(1'b1);
    checks++; if (obs !== (AWK | WOKE)) begin errors++; $display("FAIL min_sleep_wake: got %b expected %b", obs, AWK | WOKE); end
    step(1'b1);
    checks++; if (obs !== AWK) begin errors++; $display("FAIL min_sleep_stay_awake: got %b expected %b", obs, AWK); end
  endtask

  task automatic test_force_wake();
    energy_level = 2'd1;
    stress_level = 2'd0;
    step(1'b1);
    checks++; if (obs !== (ASL | FELL)) begin errors++; $display("FAIL force_fall: got %b expected %b", obs, ASL | FELL); end
    step(1'b1);
    checks++; if (obs !== ASL) begin errors++; $display("FAIL force_sleep1: got %b expected %b", obs, ASL); end
    stress_level = 2'd2;
    step(1'b1);
    checks++; if (obs !== (AWK | WOKE)) begin errors++; $display("FAIL force_wake: got %b expected %b", obs, AWK | WOKE); end
    step(1'b1);
    checks++; if (obs !== AWK) begin errors++; $display("FAIL stress_blocks_sleep: got %b expected %b", obs, AWK); end
    stress_level = 2'd1;
    step(1'b1);
    checks++; if (obs !== (ASL | FELL)) begin errors++; $display("FAIL low_stress_sleep: got %b expected %b", obs, ASL | FELL); end
  endtask

  task automatic test_death();
    do_reset();
    energy_level = 2'd0;
    step(1'b1);
    checks++; if (obs !== DYG) begin errors++; $display("FAIL death_enter: got %b expected %b", obs, DYG); end
    for (int i = 1; i <= 7; i++) begin
      step(1'b1);
      checks++; if (obs !== DYG) begin errors++; $display("FAIL death_tick%0d: got %b expected %b", i, obs, DYG); end
    end
    step(1'b1);
    checks++; if (obs !== (DED | DIED)) begin errors++; $display("FAIL death_died: got %b expected %b", obs, DED | DIED); end
    energy_level = 2'd3;
    step(1'b1);
    checks++; if (obs !== DED) begin errors++; $display("FAIL death_absorbing: got %b expected %b", obs, DED); end
  endtask

  task automatic test_dying_restore();
    do_reset();
    energy_level = 2'd0;
    step(1'b1);
    checks++; if (obs !== DYG) begin errors++; $display("FAIL restore_enter: got %b expected %b", obs, DYG); end
    for (int i = 1; i <= 6; i++) step(1'b1);
    energy_level = 2'd1;
    step(1'b1);
    checks++; if (obs !== AWK) begin errors++; $display("FAIL restore_awake: got %b expected %b", obs, AWK); end
    energy_level = 2'd0;
    step(1'b1);
    checks++; if (obs !== DYG) begin errors++; $display("FAIL restore_reenter: got %b expected %b", obs, DYG); end
    for (int i = 1; i <= 7; i++) begin
      step(1'b1);
      checks++; if (obs !== DYG) begin errors++; $display("FAIL restore_tick%0d: got %b expected %b", i, obs, DYG); end
    end
    step(1'b1);
    checks++; if (obs !== (DED | DIED)) begin errors++; $display("FAIL restore_died: got %b expected %b", obs, DED | DIED); end
  endtask

  task automatic test_tick_gating();
    do_reset();
    energy_level = 2'd0;
    for (int i = 0; i < 4; i++) step(1'b1);
    checks++; if (obs !== DYG) begin errors++; $display("FAIL gate_dying: got %b expected %b", obs, DYG); end
    for (int i = 0; i < 20; i++) begin
      step(1'b0);
      checks++; if (obs !== DYG) begin errors++; $display("FAIL gate_hold%0d: got %b expected %b", i, obs, DYG); end
    end
    rst = 1'b1;
    step(1'b1);
    checks++; if (obs !== AWK) begin errors++; $display("FAIL gate_reset: got %b expected %b", obs, AWK); end
    rst = 1'b0;
    step(1'b1);
    checks++; if (obs !== DYG) begin errors++; $display("FAIL gate_reenter: got %b expected %b", obs, DYG); end
    for (int i = 1; i <= 7; i++) begin
      step(1'b1);
      checks++; if (obs !== DYG) begin errors++; $display("FAIL gate_cnt_cleared%0d: got %b expected %b", i, obs, DYG); end
    end
    step(1'b1);
    checks++; if (obs !== (DED | DIED)) begin errors++; $display("FAIL gate_died: got %b expected %b", obs, DED | DIED); end
  endtask

  task automatic test_revive();
    logic [8:0] exp_rev, exp_after;
`ifdef VITALITY_REVIVE_EN
    exp_rev   = AWK | WOKE;
    exp_after = AWK;
`else
    exp_rev   = DED;
    exp_after = DED;
`endif
    energy_level = 2'd3;
    revive = 1'b1;
    step(1'b0);
    revive = 1'b0;
    checks++; if (obs !== exp_rev) begin errors++; $display("FAIL revive_dead: got %b expected %b", obs, exp_rev); end
    step(1'b0);
    checks++; if (obs !== exp_after) begin errors++; $display("FAIL revive_after: got %b expected %b", obs, exp_after); end
    do_reset();
    revive = 1'b1;
    step(1'b0);
    revive = 1'b0;
    checks++; if (obs !== AWK) begin errors++; $display("FAIL revive_outside_dead: got %b expected %b", obs, AWK); end
  endtask

  initial begin
    test_reset();
    test_fall_asleep();
    test_min_sleep();
    test_force_wake();
    test_death();
    test_dying_restore();
    test_tick_gating();
    test_revive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
